hs_input_packer: RTL and testbench
==================================

Name: hs_input_packer

Overview:
- Synthesizable, parametrised successor to the byte-to-16-bit packing stage that feeds the high-speed input of the pkt_comm applications (bcrypt and others).
- Reads bytes from a first-word-fall-through byte FIFO and assembles BYTES-byte words with configurable byte order.
- Writes each word into the application input buffer under almost_full backpressure.
- Adds flush with padding and overlapped emit/accept, so sustained throughput is 1 byte/cycle.

Parameters:
- BYTES, 2: bytes per output word; legal range 2..8.
- BYTE_ORDER, 0: 0 = first received byte goes to dout[7:0]; 1 = first received byte goes to dout[8*BYTES-1 -: 8].
- PAD_BYTE, 8'h00: value written into unfilled byte lanes on flush.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_dout  in  8  byte from the FWFT input FIFO.
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pop the input FIFO (combinational).
- flush  in  1  single-cycle request to emit a partial word.
- out_din  out  8*BYTES  assembled word.
- out_nbytes  out  4  count of valid bytes in out_din, 1..BYTES.
- out_wr_en  out  1  write strobe to the application input (combinational).
- out_almost_full  in  1  downstream backpressure.
- idle  out  1  high when in COLLECT with cnt==0 and no flush pending.

Behaviour:
- States:
  - COLLECT: accumulating bytes.
  - FULL: word held in the output register.
- Internal registers:
  - cnt: 0..BYTES-1.
  - word register: 8*BYTES bits.
  - nbytes register.
  - flush_pending: 1 bit.
- Reset (rst=1 at a CLK edge):
  - state=COLLECT, cnt=0, word register=0, out_nbytes=0, flush_pending=0.
  - Consequently out_wr_en=0, in_rd_en=0 while rst is asserted, and idle=1 after reset.
  - Reset mid-word discards the partial word; nothing is emitted.
- in_rd_en = ~rst & ~in_empty & (state==COLLECT | (state==FULL & ~out_almost_full)).
- out_wr_en = ~rst & state==FULL & ~out_almost_full.
- Byte accept:
  - On the in_rd_en cycle, in_dout is stored in lane cnt (BYTE_ORDER=0) or lane BYTES-1-cnt (BYTE_ORDER=1).
  - If cnt==BYTES-1: cnt<=0, nbytes<=BYTES, state<=FULL. Otherwise cnt<=cnt+1.
- Emit:
  - In FULL, the word is presented on out_din/out_nbytes and stays stable until out_wr_en.
  - On the out_wr_en cycle the state returns to COLLECT.
  - If in_rd_en is also high in that cycle, the accepted byte becomes lane 0 of the next word (cnt<=1). No bubble.
  - Lanes not yet written in the new word are cleared to PAD_BYTE as the word starts.
- Latency:
  - The final byte accepted in cycle t is visible on out_din in cycle t+1.
  - out_wr_en can assert in cycle t+1 at the earliest.
- Flush:
  - Flush in COLLECT with cnt>0, or with a byte being accepted in the same cycle:
    - The accepted byte is included first.
    - Remaining lanes are PAD_BYTE, nbytes = number of valid bytes, state<=FULL.
  - Flush in COLLECT with cnt==0 and no byte accepted: ignored.
  - Flush in FULL: sets flush_pending, which is applied on the first COLLECT cycle with the same rules, then cleared.
  - A flush that coincides with the byte completing a full word (cnt==BYTES-1 accepted) has nothing left to pad and is consumed.
- Backpressure:
  - While out_almost_full=1 in FULL, no bytes are read and the word is held.
  - The in_empty state does not affect holding.

Optional Feature:
- Macro: HS_INPUT_PACKER_STATS_EN.
- When defined, the block adds the following outputs, all cleared by rst:
  - words_out [31:0]: count of out_wr_en cycles, wrapping at 2^32.
  - stall_cycles [31:0]: count of cycles in FULL with out_almost_full=1, saturating at 32'hFFFFFFFF.
  - pad_words [15:0]: count of words emitted with nbytes<BYTES, wrapping.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- BYTES=2, BYTE_ORDER=0; bytes 8'h34, 8'h12 fed back-to-back, almost_full=0 -> one write, out_din=16'h1234, out_nbytes=2, one cycle after the second pop.
- BYTES=4, BYTE_ORDER=1; 12 bytes 01..0C continuous -> writes 32'h01020304, 32'h05060708, 32'h090A0B0C on consecutive 4-cycle intervals; in_rd_en never drops (1 byte/cycle).
- BYTES=4, PAD_BYTE=8'hFF; bytes AA, BB, then flush -> out_din=32'hFFFFBBAA, out_nbytes=2. A second flush with cnt==0 -> no write.
- BYTES=2; word complete, out_almost_full held high for 10 cycles -> out_din stable, in_rd_en=0, out_wr_en=0. Release -> a single write; with STATS_EN, stall_cycles=10.
- BYTES=2; flush pulsed while in FULL, then byte 8'h55 -> first full word written, next write is 16'h0055 with out_nbytes=1.
- Assert rst after one byte of a 2-byte word -> no write, idle=1. Next bytes 8'h11, 8'h22 -> 16'h2211.

Source files
------------

// File: rtl/hs_input_packer.sv
// hs_input_packer
//
// Purpose:
//    Packs bytes from a first-word-fall-through byte FIFO into BYTES-byte words
//    for the high-speed application input buffer. The byte order is configurable.
//    A single-cycle flush emits a partially filled word, and the empty lanes are
//    filled with PAD_BYTE. A finished word is emitted in the same cycle that the
//    first byte of the next word is accepted, so a continuous stream runs at
//    1 byte/cycle.
//
// Parameters:
//    BYTES       bytes per output word (2..8)
//    BYTE_ORDER  0: first byte lands in out_din[7:0]
//                1: first byte lands in out_din[8*BYTES-1 -: 8]
//    PAD_BYTE    fill value for lanes that were not written before a flush
//
// Ports:
//    CLK              clock
//    rst              synchronous active-high reset
//    in_dout          byte at the head of the input FIFO
//    in_empty         input FIFO empty
//    in_rd_en         pop the input FIFO (combinational)
//    flush            single-cycle request to emit a partial word
//    out_din          assembled word
//    out_nbytes       number of valid bytes in out_din
//    out_wr_en        write strobe to the application input (combinational)
//    out_almost_full  downstream backpressure
//    idle             nothing collected and no flush pending
//
// Optional feature (macro HS_INPUT_PACKER_STATS_EN):
//    words_out     [31:0] number of emitted words, wrapping
//    stall_cycles  [31:0] cycles spent holding a word under backpressure, saturating
//    pad_words     [15:0] number of emitted words with fewer than BYTES bytes, wrapping

module hs_input_packer #(
   parameter int          BYTES      = 2,
   parameter int          BYTE_ORDER = 0,
   parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic [7:0]           in_dout,
   input  logic                 in_empty,
   output logic                 in_rd_en,
   input  logic                 flush,
   output logic [8*BYTES-1:0]   out_din,
   output logic [3:0]           out_nbytes,
   output logic                 out_wr_en,
   input  logic                 out_almost_full,
   output logic                 idle
`ifdef HS_INPUT_PACKER_STATS_EN
   ,
   output logic [31:0]          words_out,
   output logic [31:0]          stall_cycles,
   output logic [15:0]          pad_words
`endif
);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } packerState_t;

   localparam logic [3:0]         LAST_IDX = 4'(BYTES - 1);
   localparam logic [3:0]         FULL_CNT = 4'(BYTES);
   localparam logic [8*BYTES-1:0] PAD_WORD = {BYTES{PAD_BYTE}};

   packerState_t        r_state;
   packerState_t        w_nextState;
   logic [3:0]          r_cnt;
   logic [3:0]          w_nextCnt;
   logic [8*BYTES-1:0]  r_word;
   logic [8*BYTES-1:0]  w_nextWord;
   logic [3:0]          r_nbytes;
   logic [3:0]          w_nextNbytes;
   logic                r_flushPending;
   logic                w_nextFlushPending;

   logic                w_emit;
   logic                w_accept;
   logic                w_flushReq;
   logic [3:0]          w_slot;
   logic [3:0]          w_lane;
   logic [8*BYTES-1:0]  w_baseWord;
   logic [8*BYTES-1:0]  w_wordWithByte;

   // A word is written whenever one is held and the downstream buffer has room.
   // A byte is taken while collecting, or while emitting, because the emit
   // frees the word register in the same cycle.
   always_comb begin
      w_emit     = ~rst & (r_state == FULL) & ~out_almost_full;
      w_accept   = ~rst & ~in_empty & ((r_state == COLLECT) | w_emit);
      w_flushReq = flush | r_flushPending;
   end

   // Build the word with the incoming byte merged in. A byte accepted while
   // emitting, or a byte arriving at cnt==0, starts a new word. A new word begins
   // as all PAD_BYTE, so lanes that a later flush leaves unwritten are already
   // padded.
   always_comb begin
      w_slot         = (r_state == FULL) ? 4'd0 : r_cnt;
      w_lane         = (BYTE_ORDER != 0) ? (LAST_IDX - w_slot) : w_slot;
      w_baseWord     = ((r_state == FULL) || (r_cnt == 4'd0)) ? PAD_WORD : r_word;
      w_wordWithByte = w_baseWord;
      for (int i = 0; i < BYTES; i++) begin
         if (4'(i) == w_lane) begin
            w_wordWithByte[8*i +: 8] = in_dout;
         end
      end
   end

   // Next-state logic. In COLLECT, a pending or fresh flush is resolved at once.
   // It closes the word if anything is in it (including a byte accepted this
   // cycle). Otherwise it is dropped. In FULL, a flush can only be remembered
   // for the next COLLECT cycle.
   always_comb begin
      w_nextState        = r_state;
      w_nextCnt          = r_cnt;
      w_nextWord         = r_word;
      w_nextNbytes       = r_nbytes;
      w_nextFlushPending = r_flushPending;

      case (r_state)
         COLLECT: begin
            w_nextFlushPending = 1'b0;
            if (w_accept) begin
               w_nextWord = w_wordWithByte;
               if (r_cnt == LAST_IDX) begin
                  w_nextState  = FULL;
                  w_nextCnt    = 4'd0;
                  w_nextNbytes = FULL_CNT;
               end else if (w_flushReq) begin
                  w_nextState  = FULL;
                  w_nextCnt    = 4'd0;
                  w_nextNbytes = r_cnt + 4'd1;
               end else begin
                  w_nextCnt = r_cnt + 4'd1;
               end
            end else if (w_flushReq && (r_cnt != 4'd0)) begin
               w_nextState  = FULL;
               w_nextCnt    = 4'd0;
               w_nextNbytes = r_cnt;
            end
         end

         FULL: begin
            if (flush) begin
               w_nextFlushPending = 1'b1;
            end
            if (w_emit) begin
               w_nextState = COLLECT;
               if (w_accept) begin
                  w_nextWord = w_wordWithByte;
                  w_nextCnt  = 4'd1;
               end else begin
                  w_nextWord = PAD_WORD;
                  w_nextCnt  = 4'd0;
               end
            end
         end

         default: begin
            w_nextState = COLLECT;
         end
      endcase
   end

   // State register. Reset drops any partial word without emitting it.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state        <= COLLECT;
         r_cnt          <= 4'd0;
         r_word         <= '0;
         r_nbytes       <= 4'd0;
         r_flushPending <= 1'b0;
      end else begin
         r_state        <= w_nextState;
         r_cnt          <= w_nextCnt;
         r_word         <= w_nextWord;
         r_nbytes       <= w_nextNbytes;
         r_flushPending <= w_nextFlushPending;
      end
   end

   // The held word drives the output directly, so it stays stable under
   // backpressure.
   always_comb begin
      in_rd_en   = w_accept;
      out_wr_en  = w_emit;
      out_din    = r_word;
      out_nbytes = r_nbytes;
      idle       = (r_state == COLLECT) && (r_cnt == 4'd0) && !r_flushPending;
   end

`ifdef HS_INPUT_PACKER_STATS_EN
   logic [31:0] r_wordsOut;
   logic [31:0] r_stallCycles;
   logic [15:0] r_padWords;

   // Statistics counters. The stall counter saturates so that a long hang
   // still reads as "very long" rather than wrapping back to a small value.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_wordsOut    <= 32'd0;
         r_stallCycles <= 32'd0;
         r_padWords    <= 16'd0;
      end else begin
         if (w_emit) begin
            r_wordsOut <= r_wordsOut + 32'd1;
            if (r_nbytes < FULL_CNT) begin
               r_padWords <= r_padWords + 16'd1;
            end
         end
         if ((r_state == FULL) && out_almost_full && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
         end
      end
   end

   always_comb begin
      words_out    = r_wordsOut;
      stall_cycles = r_stallCycles;
      pad_words    = r_padWords;
   end
`endif

endmodule

// File: tb/tb_hs_input_packer.sv
// tb_hs_input_packer
//
// Two packer instances share the clock and reset:
//    A: BYTES=2, BYTE_ORDER=0, PAD_BYTE=8'h00
//    B: BYTES=4, BYTE_ORDER=1, PAD_BYTE=8'hFF
// Expected words are queued when stimulus is issued. A monitor per instance
// pops the queue and compares it on every write strobe.

module tb_hs_input_packer;

   logic clk = 1'b0;
   logic rst;

   logic [7:0]  aInDout, bInDout;
   logic        aInEmpty, bInEmpty;
   logic        aRdEn, bRdEn;
   logic        aFlush, bFlush;
   logic [15:0] aDin;
   logic [31:0] bDin;
   logic [3:0]  aNb, bNb;
   logic        aWr, bWr;
   logic        aAf, bAf;
   logic        aIdle, bIdle;

`ifdef HS_INPUT_PACKER_STATS_EN
   logic [31:0] aWords, aStall, bWords, bStall;
   logic [15:0] aPad, bPad;
`endif

   int checks = 0;
   int errors = 0;
   int streamStalls = 0;

   logic [19:0] qA[$];
   logic [35:0] qB[$];
   logic [7:0]  txBuf[$];

   always #5 clk = ~clk;

   hs_input_packer #(.BYTES(2), .BYTE_ORDER(0), .PAD_BYTE(8'h00)) dutA (
      .CLK(clk), .rst(rst), .in_dout(aInDout), .in_empty(aInEmpty), .in_rd_en(aRdEn),
      .flush(aFlush), .out_din(aDin), .out_nbytes(aNb), .out_wr_en(aWr),
      .out_almost_full(aAf), .idle(aIdle)
`ifdef HS_INPUT_PACKER_STATS_EN
      , .words_out(aWords), .stall_cycles(aStall), .pad_words(aPad)
`endif
   );

   hs_input_packer #(.BYTES(4), .BYTE_ORDER(1), .PAD_BYTE(8'hFF)) dutB (
      .CLK(clk), .rst(rst), .in_dout(bInDout), .in_empty(bInEmpty), .in_rd_en(bRdEn),
      .flush(bFlush), .out_din(bDin), .out_nbytes(bNb), .out_wr_en(bWr),
      .out_almost_full(bAf), .idle(bIdle)
`ifdef HS_INPUT_PACKER_STATS_EN
      , .words_out(bWords), .stall_cycles(bStall), .pad_words(bPad)
`endif
   );

   // Scoreboard monitor for instance A: every write must match the oldest
   // expected {nbytes, word}.
   always @(negedge clk) begin
      if (aWr === 1'b1) begin
         checks++;
         if (qA.size() == 0) begin
            errors++;
            $display("[TB] FAIL writeA_unexpected: got %0h/%0d required no write", aDin, aNb);
         end else begin
            logic [19:0] exp;
            exp = qA.pop_front();
            if ({aNb, aDin} !== exp) begin
               errors++;
               $display("[TB] FAIL writeA: got %0h/%0d required %0h/%0d", aDin, aNb, exp[15:0], exp[19:16]);
            end
         end
      end
   end

   // Scoreboard monitor for instance B.
   always @(negedge clk) begin
      if (bWr === 1'b1) begin
         checks++;
         if (qB.size() == 0) begin
            errors++;
            $display("[TB] FAIL writeB_unexpected: got %0h/%0d required no write", bDin, bNb);
         end else begin
            logic [35:0] exp;
            exp = qB.pop_front();
            if ({bNb, bDin} !== exp) begin
               errors++;
               $display("[TB] FAIL writeB: got %0h/%0d required %0h/%0d", bDin, bNb, exp[31:0], exp[35:32]);
            end
         end
      end
   end

   // Watchdog so that the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
      end
   endtask

   // Feed txBuf into instance A (sel=0) or B (sel=1), one byte per pop.
   // Counts cycles where the FIFO was non-empty but not popped. It can raise
   // flush together with the last byte.
   task automatic applyStimulus(input bit sel, input bit flushLast);
      logic [7:0] b;
      int waited;
      while (txBuf.size() > 0) begin
         b = txBuf.pop_front();
         if (sel) begin bInDout = b; bInEmpty = 1'b0; end
         else     begin aInDout = b; aInEmpty = 1'b0; end
         if (flushLast && (txBuf.size() == 0)) begin
            if (sel) bFlush = 1'b1; else aFlush = 1'b1;
         end
         @(negedge clk);
         waited = 0;
         while (((sel ? bRdEn : aRdEn) !== 1'b1) && (waited < 50)) begin
            @(negedge clk);
            waited++;
         end
         streamStalls += waited;
         if (waited >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL rd_en_timeout: got no pop after %0d cycles required pop", waited);
         end
         tick();
         aFlush = 1'b0;
         bFlush = 1'b0;
      end
      if (sel) bInEmpty = 1'b1; else aInEmpty = 1'b1;
   endtask

   initial begin
      rst      = 1'b1;
      aInDout  = 8'hEE; bInDout = 8'h00;
      aInEmpty = 1'b0;  bInEmpty = 1'b1;
      aFlush   = 1'b0;  bFlush   = 1'b0;
      aAf      = 1'b0;  bAf      = 1'b0;

      // Reset: a non-empty FIFO must not be popped while rst is high.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rd_wr", {aRdEn, aWr, bRdEn, bWr}, 4'b0000);
      checkOutput("reset_word", {aNb, aDin}, 20'h0_0000);
      aInEmpty = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_idle", {aIdle, bIdle}, 2'b11);
      tick();

      // Two bytes on A form 16'h1234 and are written one cycle after the last pop.
      qA.push_back({4'd2, 16'h1234});
      txBuf = '{8'h34, 8'h12};
      applyStimulus(1'b0, 1'b0);
      @(negedge clk);
      checkOutput("latency_A", {aWr, aDin}, {1'b1, 16'h1234});
      repeat (3) tick();

      // Twelve bytes into B at 1 byte/cycle, byte order reversed.
      qB.push_back({4'd4, 32'h01020304});
      qB.push_back({4'd4, 32'h05060708});
      qB.push_back({4'd4, 32'h090A0B0C});
      for (int i = 1; i <= 12; i++) txBuf.push_back(8'(i));
      streamStalls = 0;
      applyStimulus(1'b1, 1'b0);
      checkOutput("rd_en_continuous_B", 64'(streamStalls), 64'd0);
      repeat (4) tick();

      // B flush after two bytes pads with FF. A second flush at cnt==0 writes nothing.
      qB.push_back({4'd2, 32'hAABBFFFF});
      txBuf = '{8'hAA, 8'hBB};
      applyStimulus(1'b1, 1'b0);
      bFlush = 1'b1;
      tick();
      bFlush = 1'b0;
      repeat (3) tick();
      bFlush = 1'b1;
      tick();
      bFlush = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checkOutput("flush_empty_idle_B", {bIdle, 28'(qB.size())}, {1'b1, 28'd0});
      tick();

      // A flush that arrives with a byte includes that byte.
      qB.push_back({4'd2, 32'hC1C2FFFF});
      txBuf = '{8'hC1, 8'hC2};
      applyStimulus(1'b1, 1'b1);
      repeat (3) tick();

`ifdef HS_INPUT_PACKER_STATS_EN
      checkOutput("stats_B", {bWords, bPad}, {32'd5, 16'd2});
`endif

      // A flush on the completing byte is consumed, so there is no extra write.
      qA.push_back({4'd2, 16'hE2E1});
      txBuf = '{8'hE1, 8'hE2};
      applyStimulus(1'b0, 1'b1);
      repeat (4) tick();
      @(negedge clk);
      checkOutput("flush_on_full_A", {aIdle, 28'(qA.size())}, {1'b1, 28'd0});
      tick();

      // Backpressure: hold 16'h7856 for 10 cycles with a byte waiting.
      aAf = 1'b1;
      qA.push_back({4'd2, 16'h7856});
      qA.push_back({4'd2, 16'hBC9A});
      txBuf = '{8'h56, 8'h78};
      applyStimulus(1'b0, 1'b0);
      aInDout  = 8'h9A;
      aInEmpty = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("hold_A", {aWr, aRdEn, aDin}, {1'b0, 1'b0, 16'h7856});
         tick();
      end
      aAf = 1'b0;
`ifdef HS_INPUT_PACKER_STATS_EN
      checkOutput("stall_cycles_A", aStall, 32'd10);
`endif
      txBuf = '{8'h9A, 8'hBC};
      applyStimulus(1'b0, 1'b0);
      repeat (3) tick();

      // A flush while FULL is held pending and then closes the word holding 55.
      aAf = 1'b1;
      qA.push_back({4'd2, 16'h2211});
      qA.push_back({4'd1, 16'h0055});
      txBuf = '{8'h11, 8'h22};
      applyStimulus(1'b0, 1'b0);
      aFlush = 1'b1;
      tick();
      aFlush = 1'b0;
      tick();
      aAf = 1'b0;
      txBuf = '{8'h55};
      applyStimulus(1'b0, 1'b0);
      repeat (4) tick();
      @(negedge clk);
      checkOutput("pending_flush_done_A", 64'(qA.size()), 64'd0);
      tick();

      // Reset mid-word drops the partial byte.
      txBuf = '{8'h77};
      applyStimulus(1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_midword_A", {aIdle, aWr, aNb}, {1'b1, 1'b0, 4'd0});
      tick();
      qA.push_back({4'd2, 16'h2211});
      txBuf = '{8'h11, 8'h22};
      applyStimulus(1'b0, 1'b0);
      repeat (4) tick();

      @(negedge clk);
      checkOutput("final_queue_A", 64'(qA.size()), 64'd0);
      checkOutput("final_queue_B", 64'(qB.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
